// File: rtl/vending_controller.sv
// Multi-item vending controller: one shared credit accumulator in 5-cent units,
// per-item prices by parameter. Define VENDING_DIME_CHANGE_EN to pay change in dimes first.
module vending_controller #(
    parameter int                            NUM_ITEMS  = 4,
    parameter int                            CREDIT_W   = 6,
    parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES     = {6'd5, 6'd4, 6'd3, 6'd2},
    parameter int                            MAX_CREDIT = 20
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [$clog2(NUM_ITEMS)-1:0] item_sel,
    input  logic                         buy,
    input  logic                         cancel,
    input  logic                         nickel_in,
    input  logic                         dime_in,
    input  logic                         quarter_in,
    output logic                         dispense,
    output logic [$clog2(NUM_ITEMS)-1:0] dispensed_item,
    output logic                         nickel_out,
`ifdef VENDING_DIME_CHANGE_EN
    output logic                         dime_out,
`endif
    output logic                         coin_reject,
    output logic                         buy_error,
    output logic [CREDIT_W-1:0]          credit,
    output logic                         busy
);

    localparam int SEL_W = $clog2(NUM_ITEMS);

    localparam logic [1:0] ST_ACCEPT = 2'd0;
    localparam logic [1:0] ST_VEND   = 2'd1;
    localparam logic [1:0] ST_CHANGE = 2'd2;

    localparam logic [SEL_W:0]    NUM_SEL = (SEL_W+1)'(NUM_ITEMS);
    localparam logic [CREDIT_W:0] MAX_EXT = (CREDIT_W+1)'(MAX_CREDIT);

    function automatic logic [CREDIT_W-1:0] price_of(input logic [SEL_W-1:0] sel);
        logic [CREDIT_W-1:0] p;
        p = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (sel == SEL_W'(i)) p = PRICES[i*CREDIT_W +: CREDIT_W];
        end
        return p;
    endfunction

    logic [1:0]          state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                dispense_q, dispense_d;
    logic [SEL_W-1:0]    item_q, item_d;
    logic                reject_q, reject_d;
    logic                berr_q, berr_d;

    logic [1:0]          coin_cnt;
    logic                any_coin;
    logic                multi_coin;
    logic [CREDIT_W:0]   coin_val;
    logic [CREDIT_W:0]   coin_sum;
    logic [CREDIT_W-1:0] price;
    logic                sel_ok;
    logic                can_buy;

    assign coin_cnt   = {1'b0, nickel_in} + {1'b0, dime_in} + {1'b0, quarter_in};
    assign any_coin   = nickel_in | dime_in | quarter_in;
    assign multi_coin = (coin_cnt > 2'd1);

    always_comb begin
        coin_val = (CREDIT_W+1)'(1);
        if (quarter_in)   coin_val = (CREDIT_W+1)'(5);
        else if (dime_in) coin_val = (CREDIT_W+1)'(2);
    end

    // One bit wider than credit so the ceiling compare cannot wrap.
    assign coin_sum = {1'b0, credit_q} + coin_val;
    assign price    = price_of(item_sel);
    assign sel_ok   = ({1'b0, item_sel} < NUM_SEL);
    assign can_buy  = sel_ok && (credit_q >= price);

    always_comb begin
        state_d    = state_q;
        credit_d   = credit_q;
        dispense_d = 1'b0;
        item_d     = item_q;
        reject_d   = 1'b0;
        berr_d     = 1'b0;
        case (state_q)
            ST_ACCEPT: begin
                if (cancel) begin
                    reject_d = any_coin;
                    if (credit_q != '0) state_d = ST_CHANGE;
                end else if (buy && can_buy) begin
                    credit_d   = credit_q - price;
                    item_d     = item_sel;
                    dispense_d = 1'b1;
                    reject_d   = any_coin;
                    state_d    = ST_VEND;
                end else begin
                    berr_d = buy;
                    if (multi_coin) begin
                        reject_d = 1'b1;
                    end else if (any_coin) begin
                        if (coin_sum <= MAX_EXT) credit_d = coin_sum[CREDIT_W-1:0];
                        else                     reject_d = 1'b1;
                    end
                end
            end
            ST_VEND: begin
                berr_d   = buy;
                reject_d = any_coin;
                state_d  = (credit_q != '0) ? ST_CHANGE : ST_ACCEPT;
            end
            ST_CHANGE: begin
                berr_d   = buy;
                reject_d = any_coin;
`ifdef VENDING_DIME_CHANGE_EN
                credit_d = (credit_q >= CREDIT_W'(2)) ? credit_q - CREDIT_W'(2) : '0;
`else
                credit_d = (credit_q != '0) ? credit_q - CREDIT_W'(1) : '0;
`endif
                if (credit_d == '0) state_d = ST_ACCEPT;
            end
            default: begin
                state_d  = ST_ACCEPT;
                credit_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_ACCEPT;
            credit_q   <= '0;
            dispense_q <= 1'b0;
            item_q     <= '0;
            reject_q   <= 1'b0;
            berr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            dispense_q <= dispense_d;
            item_q     <= item_d;
            reject_q   <= reject_d;
            berr_q     <= berr_d;
        end
    end

    assign dispense       = dispense_q;
    assign dispensed_item = item_q;
    assign coin_reject    = reject_q;
    assign buy_error      = berr_q;
    assign credit         = credit_q;
    assign busy           = (state_q != ST_ACCEPT);

`ifdef VENDING_DIME_CHANGE_EN
    assign dime_out   = (state_q == ST_CHANGE) && (credit_q >= CREDIT_W'(2));
    assign nickel_out = (state_q == ST_CHANGE) && (credit_q == CREDIT_W'(1));
`else
    assign nickel_out = (state_q == ST_CHANGE);
`endif

endmodule

// File: tb/tb_vending_controller.sv
// Scoreboard bench for vending_controller: per-cycle expectations are queued as
// stimulus is driven and compared on the falling edge of the cycle they describe.
module tb_vending_controller;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] item_sel = 2'd0;
    logic       buy = 1'b0;
    logic       cancel = 1'b0;
    logic       nickel_in = 1'b0;
    logic       dime_in = 1'b0;
    logic       quarter_in = 1'b0;
    logic       dispense;
    logic [1:0] dispensed_item;
    logic       nickel_out;
    logic       coin_reject;
    logic       buy_error;
    logic [5:0] credit;
    logic       busy;
    logic       dime_obs;
`ifdef VENDING_DIME_CHANGE_EN
    logic       dime_out;
    assign dime_obs = dime_out;
`else
    assign dime_obs = 1'b0;
`endif

    vending_controller dut (
        .clock          (clock),
        .reset          (reset),
        .item_sel       (item_sel),
        .buy            (buy),
        .cancel         (cancel),
        .nickel_in      (nickel_in),
        .dime_in        (dime_in),
        .quarter_in     (quarter_in),
        .dispense       (dispense),
        .dispensed_item (dispensed_item),
        .nickel_out     (nickel_out),
`ifdef VENDING_DIME_CHANGE_EN
        .dime_out       (dime_out),
`endif
        .coin_reject    (coin_reject),
        .buy_error      (buy_error),
        .credit         (credit),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    int cyc_cnt = 0;
    always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

    typedef struct {
        int         cyc;
        string      tag;
        logic [5:0] cr;
        logic       disp;
        logic [1:0] item;
        logic       nick;
        logic       dime;
        logic       rej;
        logic       berr;
        logic       busy;
    } exp_t;

    exp_t  sb[$];
    string cur_test = "none";
    int    checks = 0;
    int    errors = 0;

    localparam logic [2:0] NONE = 3'b000, NK = 3'b001, DM = 3'b010, QT = 3'b100;

    function automatic logic [5:0] nxt(input logic [5:0] c);
`ifdef VENDING_DIME_CHANGE_EN
        return (c >= 6'd2) ? c - 6'd2 : 6'd0;
`else
        return (c != 6'd0) ? c - 6'd1 : 6'd0;
`endif
    endfunction

    function automatic logic nick_e(input logic [5:0] c);
`ifdef VENDING_DIME_CHANGE_EN
        return (c == 6'd1);
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic dime_e(input logic [5:0] c);
`ifdef VENDING_DIME_CHANGE_EN
        return (c >= 6'd2);
`else
        return 1'b0;
`endif
    endfunction

    // Falling edge: retire expectations due this cycle, then drive the next cycle's inputs.
    task automatic step(input logic [2:0] coins, input logic b, input logic [1:0] sel, input logic c);
        exp_t e;
        @(negedge clock);
        while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
            e = sb.pop_front();
            checks++;
            if (e.cyc != cyc_cnt) begin
                errors++;
                $display("FAIL %s stale: entry for cycle %0d still pending at cycle %0d", e.tag, e.cyc, cyc_cnt);
            end else if ({credit, dispense, nickel_out, dime_obs, coin_reject, buy_error, busy} !==
                         {e.cr, e.disp, e.nick, e.dime, e.rej, e.berr, e.busy}) begin
                errors++;
                $display("FAIL %s@%0d got credit=%0d disp=%b nick=%b dime=%b rej=%b berr=%b busy=%b, required credit=%0d disp=%b nick=%b dime=%b rej=%b berr=%b busy=%b",
                         e.tag, cyc_cnt, credit, dispense, nickel_out, dime_obs, coin_reject, buy_error, busy,
                         e.cr, e.disp, e.nick, e.dime, e.rej, e.berr, e.busy);
            end
            if (e.cyc == cyc_cnt && e.disp) begin
                checks++;
                if (dispensed_item !== e.item) begin
                    errors++;
                    $display("FAIL %s@%0d dispensed_item got %0d required %0d", e.tag, cyc_cnt, dispensed_item, e.item);
                end
            end
        end
        {quarter_in, dime_in, nickel_in} = coins;
        buy      = b;
        item_sel = sel;
        cancel   = c;
    endtask

    task automatic expect_out(input logic [5:0] cr, input logic disp, input logic [1:0] item,
                              input logic nick, input logic dime, input logic rej,
                              input logic berr, input logic bsy);
        exp_t e;
        e.cyc = cyc_cnt + 1; e.tag = cur_test; e.cr = cr; e.disp = disp; e.item = item;
        e.nick = nick; e.dime = dime; e.rej = rej; e.berr = berr; e.busy = bsy;
        sb.push_back(e);
    endtask

    task automatic exp_acc(input logic [5:0] cr, input logic rej, input logic berr);
        expect_out(cr, 1'b0, 2'd0, 1'b0, 1'b0, rej, berr, 1'b0);
    endtask

    task automatic exp_vend(input logic [5:0] cr, input logic [1:0] item, input logic rej);
        expect_out(cr, 1'b1, item, 1'b0, 1'b0, rej, 1'b0, 1'b1);
    endtask

    task automatic exp_chg(input logic [5:0] cr, input logic rej, input logic berr);
        expect_out(cr, 1'b0, 2'd0, nick_e(cr), dime_e(cr), rej, berr, 1'b1);
    endtask

    // Idle cycles until the change for credit c is paid out and ACCEPT is reached.
    task automatic drain(input logic [5:0] c0);
        logic [5:0] c;
        c = c0;
        while (c != 6'd0) begin
            step(NONE, 0, 2'd0, 0); exp_chg(c, 0, 0);
            c = nxt(c);
        end
        step(NONE, 0, 2'd0, 0); exp_acc(6'd0, 0, 0);
    endtask

    task automatic test_reset;
        cur_test = "reset";
        reset = 1'b1;
        repeat (2) @(negedge clock);
        checks++;
        if ({credit, dispense, dispensed_item, nickel_out, dime_obs, coin_reject, buy_error, busy} !== 14'd0) begin
            errors++;
            $display("FAIL reset_state got credit=%0d disp=%b item=%0d nick=%b dime=%b rej=%b berr=%b busy=%b required all zero",
                     credit, dispense, dispensed_item, nickel_out, dime_obs, coin_reject, buy_error, busy);
        end
        @(posedge clock);
        #1 reset = 1'b0;
        step(NONE, 0, 2'd0, 0); exp_acc(6'd0, 0, 0);
    endtask

    task automatic test_quarter_buy;
        cur_test = "quarter_buy";
        step(QT,   0, 2'd0, 0); exp_acc(6'd5, 0, 0);
        step(NONE, 1, 2'd3, 0); exp_vend(6'd0, 2'd3, 0);
        drain(6'd0);
    endtask

    task automatic test_change;
        cur_test = "change";
        step(DM,   0, 2'd0, 0); exp_acc(6'd2, 0, 0);
        step(DM,   0, 2'd0, 0); exp_acc(6'd4, 0, 0);
        step(NK,   0, 2'd0, 0); exp_acc(6'd5, 0, 0);
        step(NONE, 1, 2'd0, 0); exp_vend(6'd3, 2'd0, 0);
        drain(6'd3);
    endtask

    task automatic test_buy_error;
        cur_test = "buy_error";
        step(NONE, 0, 2'd0, 1); exp_acc(6'd0, 0, 0);
        step(NK,   0, 2'd0, 0); exp_acc(6'd1, 0, 0);
        step(NONE, 1, 2'd2, 0); exp_acc(6'd1, 0, 1);
        step(NONE, 0, 2'd0, 1); exp_chg(6'd1, 0, 0);
        drain(nxt(6'd1));
        cur_test = "buy_error_coin";
        step(NK,   0, 2'd0, 0); exp_acc(6'd1, 0, 0);
        step(DM,   1, 2'd2, 0); exp_acc(6'd3, 0, 1);
        step(NONE, 0, 2'd0, 1); exp_chg(6'd3, 0, 0);
        drain(nxt(6'd3));
    endtask

    task automatic test_ceiling;
        cur_test = "ceiling";
        step(QT,   0, 2'd0, 0); exp_acc(6'd5, 0, 0);
        step(QT,   0, 2'd0, 0); exp_acc(6'd10, 0, 0);
        step(QT,   0, 2'd0, 0); exp_acc(6'd15, 0, 0);
        step(DM,   0, 2'd0, 0); exp_acc(6'd17, 0, 0);
        step(NK,   0, 2'd0, 0); exp_acc(6'd18, 0, 0);
        step(QT,   0, 2'd0, 0); exp_acc(6'd18, 1, 0);
        step(NK|DM,0, 2'd0, 0); exp_acc(6'd18, 1, 0);
        step(DM,   0, 2'd0, 0); exp_acc(6'd20, 0, 0);
        step(NK,   0, 2'd0, 0); exp_acc(6'd20, 1, 0);
        step(NONE, 0, 2'd0, 1); exp_chg(6'd20, 0, 0);
        drain(nxt(6'd20));
    endtask

    task automatic test_buy_with_coin;
        cur_test = "buy_with_coin";
        step(DM,   0, 2'd0, 0); exp_acc(6'd2, 0, 0);
        step(DM,   0, 2'd0, 0); exp_acc(6'd4, 0, 0);
        step(QT,   1, 2'd1, 0); exp_vend(6'd1, 2'd1, 1);
        step(NONE, 0, 2'd0, 0); exp_chg(6'd1, 0, 0);
        step(NK,   0, 2'd0, 0); exp_acc(6'd0, 1, 0);
        step(NONE, 0, 2'd0, 0); exp_acc(6'd0, 0, 0);
    endtask

    task automatic test_back_to_back;
        cur_test = "back_to_back";
        step(QT,   0, 2'd0, 0); exp_acc(6'd5, 0, 0);
        step(QT,   0, 2'd0, 0); exp_acc(6'd10, 0, 0);
        step(NONE, 1, 2'd3, 0); exp_vend(6'd5, 2'd3, 0);
        step(NK,   1, 2'd0, 0); exp_chg(6'd5, 1, 1);
        step(NONE, 0, 2'd0, 1); exp_chg(nxt(6'd5), 0, 0);
        drain(nxt(nxt(6'd5)));
        step(QT,   0, 2'd0, 0); exp_acc(6'd5, 0, 0);
        step(NONE, 1, 2'd3, 0); exp_vend(6'd0, 2'd3, 0);
        step(NONE, 1, 2'd0, 0); exp_acc(6'd0, 0, 1);
        step(NONE, 0, 2'd0, 0); exp_acc(6'd0, 0, 0);
    endtask

    task automatic test_reset_midrefund;
        cur_test = "reset_midrefund";
        step(QT,   0, 2'd0, 0); exp_acc(6'd5, 0, 0);
        step(NONE, 0, 2'd0, 1); exp_chg(6'd5, 0, 0);
        step(NONE, 0, 2'd0, 0); exp_chg(nxt(6'd5), 0, 0);
        step(NONE, 0, 2'd0, 0);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({nickel_out, dime_obs, credit, busy} !== 9'd0) begin
            errors++;
            $display("FAIL reset_midrefund_async got nick=%b dime=%b credit=%0d busy=%b required all zero",
                     nickel_out, dime_obs, credit, busy);
        end
        @(posedge clock);
        #1 reset = 1'b0;
        step(QT,   0, 2'd0, 0); exp_acc(6'd5, 0, 0);
        step(NONE, 0, 2'd0, 1); exp_chg(6'd5, 0, 0);
        drain(nxt(6'd5));
    endtask

    initial begin
        test_reset;
        test_quarter_buy;
        test_change;
        test_buy_error;
        test_ceiling;
        test_buy_with_coin;
        test_back_to_back;
        test_reset_midrefund;
        cur_test = "final";
        step(NONE, 0, 2'd0, 0);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending entries required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation exceeded time limit at cycle %0d", cyc_cnt);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vending_controller.md
Name: vending_controller

Overview:
Parametrised multi-item vending controller. It replaces the per-item fixed-price FSMs with one shared credit accumulator and per-item prices set by parameters. It accepts nickels, dimes and quarters, dispenses the selected item, and returns surplus credit serially as nickels. It also supports cancel/refund. It sits between the coin-acceptor front end and the dispense/change actuators.

Parameters:
- NUM_ITEMS, 4, number of selectable items (>=2).
- CREDIT_W, 6, width of the credit register. Credit is counted in 5¢ units.
- PRICES, {6'd5,6'd4,6'd3,6'd2}, packed NUM_ITEMS*CREDIT_W vector. Item i's price is in bits [i*CREDIT_W +: CREDIT_W], in 5¢ units. The default gives 10/15/20/25¢ for items 0..3. Each price must be >0.
- MAX_CREDIT, 20, credit ceiling in 5¢ units (<= 2**CREDIT_W-1).

Ports:
- clock, input, 1, rising-edge clock.
- reset, input, 1, asynchronous active-high reset.
- item_sel, input, $clog2(NUM_ITEMS), item index for a purchase.
- buy, input, 1, one-cycle purchase request for item_sel.
- cancel, input, 1, one-cycle refund request.
- nickel_in, input, 1, one-cycle pulse per nickel inserted.
- dime_in, input, 1, one-cycle pulse per dime inserted.
- quarter_in, input, 1, one-cycle pulse per quarter inserted.
- dispense, output, 1, one-cycle pulse releasing the item.
- dispensed_item, output, $clog2(NUM_ITEMS), index of the item being dispensed; valid while dispense=1.
- nickel_out, output, 1, one pulse per nickel of change.
- coin_reject, output, 1, one-cycle pulse: the coin was not accepted and is returned mechanically.
- buy_error, output, 1, one-cycle pulse: the buy was refused.
- credit, output, CREDIT_W, current credit in 5¢ units.
- busy, output, 1, high in any state other than ACCEPT.

Behaviour:
- Reset (async):
  - state=ACCEPT, credit=0.
  - All pulse outputs 0; dispensed_item=0.
- All outputs are registered except nickel_out and busy, which decode from state.
- Coin values: nickel=1, dime=2, quarter=5.
- ACCEPT state, priority per cycle is cancel > buy > coin.
  - **cancel:** if credit>0, go to CHANGE; else no effect. Any coin in the same cycle is rejected.
  - **buy with item_sel>=NUM_ITEMS, or credit<PRICES[item_sel]:** buy_error=1 next cycle; credit unchanged. Any same-cycle coin is still processed normally.
  - **buy with credit>=price:** credit <= credit-price, dispensed_item <= item_sel, go to VEND. Any same-cycle coin is rejected.
  - **exactly one coin, no cancel/accepted buy:**
    - If credit+value <= MAX_CREDIT, credit += value.
    - Else coin_reject=1 and credit is unchanged.
  - **more than one coin in the same cycle:** all are rejected (coin_reject=1) and credit is unchanged.
- VEND state:
  - dispense=1 for exactly one cycle.
  - Next state is CHANGE if credit!=0, else ACCEPT.
  - Buy asserts buy_error; coins assert coin_reject; cancel is ignored.
- CHANGE state:
  - nickel_out=1 every cycle; credit decrements by 1 each edge.
  - Go to ACCEPT on the edge where credit reaches 0, so nickel_out is high for exactly the remaining-credit number of cycles.
  - Buy asserts buy_error; coins assert coin_reject; cancel is ignored.
- Latency:
  - Accepted buy at edge N → dispense high in cycle N+1.
  - First nickel_out in cycle N+2.
  - Back in ACCEPT after N+2+change.
- Reset mid-VEND or mid-CHANGE: immediately return to ACCEPT with credit=0. Untransferred change is forfeited and the controller stays consistent.
- Illegal state encodings recover to ACCEPT with credit=0.
- Arithmetic: the sum is computed at CREDIT_W+1 bits for the ceiling compare, so credit never wraps.

Optional Feature:
- Macro: VENDING_DIME_CHANGE_EN.
- When defined, a dime_out output (1 bit) is added.
  - In CHANGE, if credit>=2: dime_out=1, nickel_out=0, and credit decrements by 2.
  - If credit==1: nickel_out=1 and credit decrements by 1.
  - Change is therefore paid in dimes first, with at most one nickel.
- When undefined: no dime_out port, and change is nickels only as described above.

Test Plan:
- Reset, then quarter_in → credit=5. Buy item_sel=3 (25¢) → dispense in the next cycle, dispensed_item=3, no nickel_out, credit=0, back in ACCEPT.
- Dime, dime, nickel (credit=5), then buy item 0 (10¢) → dispense, then nickel_out high for 3 consecutive cycles, credit counts 3→0.
- credit=1, buy item 2 → buy_error pulse, credit stays 1. Then cancel → nickel_out high for 1 cycle, credit=0.
- credit=18, then quarter_in → coin_reject, credit stays 18. Then nickel_in and dime_in in the same cycle → coin_reject, credit stays 18.
- buy item 1 plus quarter_in in the same cycle with credit=4 → dispense, coin_reject, change=1 nickel. Coin during CHANGE → coin_reject, credit is not increased.
- Assert reset in the second nickel_out cycle of a 5-nickel refund → nickel_out=0 and credit=0 immediately. The next quarter is accepted normally. With VENDING_DIME_CHANGE_EN, a 5-unit refund gives dime_out ×2, then nickel_out ×1.
